// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel (req/gnt, then rvalid/rdata).
interface instr_fetch_unit_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   // Fetch side issues requests and consumes responses.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   // Memory side accepts requests and returns instruction words.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs; clear has priority over push/pop.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count     = wr_ptr_q - rd_ptr_q;
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign head_data = mem_q[rd_ptr_q[PW-1:0]];

   // Next-state for storage and pointers.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   // Storage and pointer registers; contents reset so the head reads zero.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, PC advance pulses, flush/drop
// handling, and a small buffer feeding decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                areset,
   input  logic [XLEN-1:0]     pc_in,
   output logic                pc_load,
   input  logic                flush,
   instr_fetch_unit_if.master  imem,
   output logic                instr_valid,
   output logic [XLEN-1:0]     instr_out,
   output logic [XLEN-1:0]     instr_pc,
   input  logic                instr_ready
);

   localparam int PW = $clog2(DEPTH);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            drop_q, drop_d;

   logic            buf_push;
   logic            buf_pop;
   logic            buf_full;
   logic            buf_empty;
   logic [PW:0]     buf_count;
   logic [2*XLEN-1:0] buf_head;
   logic            space_after;

   // A response is kept only if no flush touched its request.
   assign buf_push = (state_q == RSP) && imem.imem_rvalid && !drop_q && !flush;
   assign buf_pop  = !buf_empty && instr_ready;

   // Occupancy after this cycle's push/pop decides whether to chain a request.
   always_comb begin
      space_after = (int'(buf_count) + int'(buf_push) - int'(buf_pop)) < DEPTH;
   end

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_buf (
      .clk       (clk),
      .areset    (areset),
      .push      (buf_push),
      .pop       (buf_pop),
      .clear     (flush),
      .push_data ({addr_q, imem.imem_rdata}),
      .head_data (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // Request FSM, drop flag and address latch next-state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE: begin
            if (!buf_full && !flush) begin
               state_d = REQ;
               addr_d  = pc_in;
            end
         end
         REQ: begin
            // The request stays up with its old address; its data is dropped.
            if (flush) drop_d = 1'b1;
            if (imem.imem_gnt) state_d = RSP;
         end
         RSP: begin
            if (imem.imem_rvalid) begin
               drop_d = 1'b0;
               if (space_after && !flush) begin
                  state_d = REQ;
                  addr_d  = pc_in;
               end else begin
                  state_d = IDLE;
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, address and drop registers.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
      end
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = addr_q;
   assign pc_load        = flush || ((state_q == REQ) && imem.imem_gnt);

   assign instr_valid = !buf_empty;
   assign instr_out   = buf_head[XLEN-1:0];
   assign instr_pc    = buf_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural PC register.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        areset;
   logic [31:0] pc_q;
   logic        pc_load;
   logic        flush;
   logic [31:0] br_target;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit_if mem_if ();

   instr_fetch_unit #(.DEPTH(2)) dut (
      .clk         (clk),
      .areset      (areset),
      .pc_in       (pc_q),
      .pc_load     (pc_load),
      .flush       (flush),
      .imem        (mem_if),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   // Program counter register: +4 on load, branch target when flushing.
   always @(posedge clk or negedge areset) begin
      if (!areset)      pc_q <= 32'h0;
      else if (pc_load) pc_q <= flush ? br_target : pc_q + 32'd4;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1'b0;
      mem_if.imem_gnt    = 1'b0;
      mem_if.imem_rvalid = 1'b0;
      mem_if.imem_rdata  = 32'h0;
      flush = 1'b0;
      step();
      areset = 1'b1;
   endtask

   // From REQ: grant this cycle, respond the next; ends with state updated.
   task automatic grant_and_respond(input logic [31:0] data);
      mem_if.imem_gnt = 1'b1;
      step();
      mem_if.imem_gnt    = 1'b0;
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = data;
      step();
      mem_if.imem_rvalid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      areset = 1'b0;
      flush = 1'b0;
      br_target = 32'h0;
      instr_ready = 1'b0;
      mem_if.imem_gnt    = 1'b0;
      mem_if.imem_rvalid = 1'b0;
      mem_if.imem_rdata  = 32'h0;
      step();
      step();

      // Reset values
      chk("rst_req",   32'(mem_if.imem_req), 32'h0);
      chk("rst_addr",  mem_if.imem_addr,     32'h0);
      chk("rst_pcld",  32'(pc_load),         32'h0);
      chk("rst_vld",   32'(instr_valid),     32'h0);
      chk("rst_iout",  instr_out,            32'h0);
      chk("rst_ipc",   instr_pc,             32'h0);

      // Best-case single fetch
      areset = 1'b1;
      instr_ready = 1'b1;
      step();
      chk("t1_req",   32'(mem_if.imem_req), 32'h1);
      chk("t1_addr0", mem_if.imem_addr,     32'h0);
      mem_if.imem_gnt = 1'b1;
      #1 chk("t1_pcld_gnt", 32'(pc_load), 32'h1);
      step();
      mem_if.imem_gnt    = 1'b0;
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = 32'h00500093;
      #1 chk("t1_pcld_rsp", 32'(pc_load), 32'h0);
      step();
      mem_if.imem_rvalid = 1'b0;
      chk("t1_vld",   32'(instr_valid),     32'h1);
      chk("t1_iout",  instr_out,            32'h00500093);
      chk("t1_ipc",   instr_pc,             32'h0);
      chk("t1_req2",  32'(mem_if.imem_req), 32'h1);
      chk("t1_addr4", mem_if.imem_addr,     32'h4);
      chk("t1_pc",    pc_q,                 32'h4);

      // Decode stalled: buffer fills after two requests, then drains in order
      do_reset();
      instr_ready = 1'b0;
      step();
      chk("t2_addr0", mem_if.imem_addr, 32'h0);
      grant_and_respond(32'hA0A0_0000);
      chk("t2_req1",  32'(mem_if.imem_req), 32'h1);
      chk("t2_addr4", mem_if.imem_addr,     32'h4);
      grant_and_respond(32'hA4A4_0004);
      for (int i = 0; i < 3; i++) begin
         chk("t2_noreq", 32'(mem_if.imem_req), 32'h0);
         step();
      end
      chk("t2_head0",  instr_out, 32'hA0A0_0000);
      chk("t2_hpc0",   instr_pc,  32'h0);
      instr_ready = 1'b1;
      step();
      chk("t2_head4",  instr_out,            32'hA4A4_0004);
      chk("t2_hpc4",   instr_pc,             32'h4);
      chk("t2_idle",   32'(mem_if.imem_req), 32'h0);
      step();
      chk("t2_empty",  32'(instr_valid),     32'h0);
      chk("t2_req8",   32'(mem_if.imem_req), 32'h1);
      chk("t2_addr8",  mem_if.imem_addr,     32'h8);

      // Flush while waiting for the response to addr 8
      mem_if.imem_gnt = 1'b1;
      #1 chk("t3_pcld_gnt", 32'(pc_load), 32'h1);
      step();
      mem_if.imem_gnt = 1'b0;
      flush = 1'b1;
      br_target = 32'h100;
      #1 chk("t3_pcld_fl", 32'(pc_load), 32'h1);
      step();
      flush = 1'b0;
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = 32'hDEAD_BEEF;
      #1 chk("t3_pcld_rv", 32'(pc_load), 32'h0);
      step();
      mem_if.imem_rvalid = 1'b0;
      chk("t3_vld",  32'(instr_valid), 32'h0);
      chk("t3_addr", mem_if.imem_addr, 32'h100);
      chk("t3_pc",   pc_q,             32'h100);

      // Flush coinciding with rvalid while one entry is buffered
      instr_ready = 1'b0;
      grant_and_respond(32'h1111_1111);
      chk("t4_vld1", 32'(instr_valid), 32'h1);
      chk("t4_iout", instr_out,        32'h1111_1111);
      chk("t4_ipc",  instr_pc,         32'h100);
      mem_if.imem_gnt = 1'b1;
      step();
      mem_if.imem_gnt    = 1'b0;
      flush              = 1'b1;
      br_target          = 32'h200;
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = 32'h2222_2222;
      step();
      flush = 1'b0;
      mem_if.imem_rvalid = 1'b0;
      chk("t4_vld0", 32'(instr_valid),     32'h0);
      chk("t4_idle", 32'(mem_if.imem_req), 32'h0);
      step();
      chk("t4_req",  32'(mem_if.imem_req), 32'h1);
      chk("t4_addr", mem_if.imem_addr,     32'h200);

      // Grant withheld for five cycles
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t5_req",  32'(mem_if.imem_req), 32'h1);
         chk("t5_addr", mem_if.imem_addr,     32'h200);
         chk("t5_pcld", 32'(pc_load),         32'h0);
         step();
      end
      mem_if.imem_gnt = 1'b1;
      #1 chk("t5_pcld_gnt", 32'(pc_load), 32'h1);
      step();
      mem_if.imem_gnt = 1'b0;

      // Asynchronous reset during RSP, then a stray rvalid
      areset = 1'b0;
      #1;
      chk("t6_req",  32'(mem_if.imem_req), 32'h0);
      chk("t6_addr", mem_if.imem_addr,     32'h0);
      chk("t6_pcld", 32'(pc_load),         32'h0);
      chk("t6_vld",  32'(instr_valid),     32'h0);
      chk("t6_iout", instr_out,            32'h0);
      chk("t6_ipc",  instr_pc,             32'h0);
      step();
      areset = 1'b1;
      mem_if.imem_rvalid = 1'b1;
      mem_if.imem_rdata  = 32'h3333_3333;
      step();
      chk("t6_late_vld", 32'(instr_valid), 32'h0);
      step();
      mem_if.imem_rvalid = 1'b0;
      chk("t6_late_vld2", 32'(instr_valid), 32'h0);
      chk("t6_addr_pc0",  mem_if.imem_addr, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly downstream of the program counter register. Takes the current PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and pulses `pc_load` to advance the PC when a request is granted. Returned instructions go into a small buffer and are handed to decode with a valid/ready handshake. A `flush` from execute (taken branch) discards buffered and in-flight instructions and redirects the PC.

## Interface
- `DEPTH`, default 2: instruction buffer entries (power of 2, ≥2).
- `clk` in 1: clock, rising edge.
- `areset` in 1: reset, asynchronous, active-low.
- `pc_in` in 32: current PC from the program counter register.
- `pc_load` out 1: one-cycle load pulse to the program counter.
- `flush` in 1: taken-branch redirect from execute; the same cycle, PCSrc=1 is driven to the PC.
- `imem_req` out 1: memory request.
- `imem_addr` out 32: request address, held stable while `imem_req`=1.
- `imem_gnt` in 1: request accepted.
- `imem_rvalid` in 1: response valid (≥1 cycle after gnt).
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: buffer head valid.
- `instr_out` out 32: head instruction.
- `instr_pc` out 32: address the head instruction was fetched from.
- `instr_ready` in 1: decode accepts the head.

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE → REQ when the buffer has a free entry and `flush`=0. `imem_addr` ← `pc_in` is latched on entry.
- REQ: `imem_req`=1 and the address is held. On `imem_gnt` → RSP.
- RSP: wait for `imem_rvalid`.
  - If `drop`=0, push {`imem_addr`, `imem_rdata`} into the buffer.
  - Clear `drop`.
  - Go to REQ (latching the new `pc_in`) if the buffer has space after this cycle's push/pop and `flush`=0; otherwise go to IDLE.
- At most one outstanding request.
- `pc_load` = `flush` | (state==REQ & `imem_gnt`). It is a single pulse even if both terms are true.
- Flush:
  - Clears the buffer the same edge; the clear wins over a simultaneous push or pop.
  - In REQ or RSP, sets `drop`. In REQ the request stays asserted with its old address until gnt, and its response is discarded.
  - `flush` together with `imem_rvalid`: the response is discarded.
  - `flush` in IDLE: no request starts that cycle.
- Buffer:
  - Pop when `instr_valid` & `instr_ready`.
  - Push and pop in the same cycle are allowed when the buffer is full.
  - `instr_valid` = not empty.
  - Full buffer: no new request is issued.
- Reset: state IDLE, buffer empty, `drop`=0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `pc_load`=0, `instr_valid`=0, `instr_out`=0, `instr_pc`=0.
- `pc_load` and `imem_req` are combinational from state plus `imem_gnt`/`flush`. All other outputs are registered.
- Best case (gnt in the req cycle, rvalid the next cycle): one instruction every 2 cycles. `instr_valid` rises the cycle after rvalid.
- `pc_in` must reflect `pc_load` by the next edge; the program counter register satisfies this.
- `areset` mid-request: everything returns to reset immediately. A late rvalid arriving in IDLE is ignored.

## Structure
- Package `fetch_pkg`: the state enum `fetch_state_t` (IDLE, REQ, RSP) and `XLEN`=32.
- Sub-module `fetch_buffer`: DEPTH-entry FIFO of 64-bit {pc, instr} with push, pop, clear, full, empty.
- FSM, `drop` flag and address latch live in `instr_fetch_unit`.

## Test plan
- Reset, pc_in=0, gnt=1 immediately, rvalid 1 cycle later, rdata=0x00500093, ready=1 → `pc_load` pulses once. `instr_valid`=1 with `instr_out`=0x00500093 and `instr_pc`=0, then the next request uses addr 4.
- `instr_ready`=0 with DEPTH=2 → exactly 2 requests are issued (addr 0, 4), then `imem_req` stays 0. Raising ready drains 0 then 4 in order and fetching resumes at 8.
- `flush` while in RSP for addr 8, rvalid arrives the next cycle → that response is not pushed, the buffer is empty, and `pc_load` pulsed once in the flush cycle.
- `flush` and `imem_rvalid` in the same cycle with 1 entry buffered → buffer empty next cycle, `instr_valid`=0.
- gnt held low 5 cycles → `imem_req`=1 and `imem_addr` unchanged throughout, and `pc_load` stays 0 until the gnt cycle.
- `areset` low during RSP → all outputs are 0 immediately. An rvalid arriving after release does not set `instr_valid`.
